// File: rtl/irq_controller_if.sv
// Signal bundle between the CPU / button chain (master) and the interrupt controller (slave).
interface irq_controller_if #(
    parameter int N_SRC  = 4,
    parameter int ADDR_W = 4
);
    logic              irq;
    logic [N_SRC-1:0]  ie;
    logic              ei;
    logic              di;
    logic              int_req;
    logic              int_ack;
    logic              reti;
    logic [ADDR_W-1:0] vector;
    logic              vec_valid;
    logic              ack;
    logic              in_service;
    logic              spurious;

    modport master (
        output irq, ie, ei, di, int_ack, reti,
        input  int_req, vector, vec_valid, ack, in_service, spurious
    );

    modport slave (
        input  irq, ie, ei, di, int_ack, reti,
        output int_req, vector, vec_valid, ack, in_service, spurious
    );
endinterface

// File: rtl/irq_controller.sv
// Single-level interrupt controller: synchronizes the shared irq line, handshakes with the CPU
// and resolves the lowest-index owning button to a jump vector.
//
// state   | meaning
// IDLE    | waiting for synchronized irq with interrupts enabled
// REQ     | int_req asserted, waiting for CPU acknowledge
// ACK     | one cycle: vector valid, ack pulse to buttons
// SERVICE | handler running, new requests ignored until reti
// HOLD    | one cycle for buttons to drop irq before re-arming
module irq_controller #(
    parameter int                N_SRC      = 4,
    parameter int                ADDR_W     = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 4'h8,
    parameter int                VEC_STRIDE = 1,
    parameter logic [ADDR_W-1:0] SPUR_VEC   = 4'hF
) (
    input logic           clock,
    input logic           reset,
    irq_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, ACK, SERVICE, HOLD} state_t;

    state_t            state;
    logic              irq_meta;
    logic              irq_s;
    logic              ien;
    logic              int_req_r;
    logic              vec_valid_r;
    logic              ack_r;
    logic              in_service_r;
    logic              spurious_r;
    logic [ADDR_W-1:0] vector_r;

    int                win_idx;
    logic              owner;
    logic [ADDR_W-1:0] win_vec;

    // Scan from the top so the lowest set bit is the one that sticks.
    always_comb begin
        win_idx = 0;
        owner   = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (bus.ie[i]) begin
                win_idx = i;
                owner   = 1'b1;
            end
        end
        win_vec = ADDR_W'(int'(VEC_BASE) + win_idx * VEC_STRIDE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            irq_meta     <= 1'b0;
            irq_s        <= 1'b0;
            ien          <= 1'b0;
            int_req_r    <= 1'b0;
            vec_valid_r  <= 1'b0;
            ack_r        <= 1'b0;
            in_service_r <= 1'b0;
            spurious_r   <= 1'b0;
            vector_r     <= '0;
        end else begin
            irq_meta    <= bus.irq;
            irq_s       <= irq_meta;
            vec_valid_r <= 1'b0;
            ack_r       <= 1'b0;

            if (bus.di) begin
                ien <= 1'b0;
            end else if (bus.ei) begin
                ien <= 1'b1;
            end

            // A fresh spurious acknowledge below takes precedence over a same-cycle ei.
            if (bus.ei) begin
                spurious_r <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (irq_s && ien) begin
                        state     <= REQ;
                        int_req_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.int_ack) begin
                        state        <= ACK;
                        int_req_r    <= 1'b0;
                        vec_valid_r  <= 1'b1;
                        in_service_r <= 1'b1;
                        if (owner) begin
                            vector_r <= win_vec;
                            ack_r    <= 1'b1;
                        end else begin
                            vector_r   <= SPUR_VEC;
                            spurious_r <= 1'b1;
                        end
                    end else if (!irq_s || bus.di) begin
                        state     <= IDLE;
                        int_req_r <= 1'b0;
                    end
                end
                ACK: begin
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (bus.reti) begin
                        state        <= HOLD;
                        in_service_r <= 1'b0;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.int_req    = int_req_r;
    assign bus.vec_valid  = vec_valid_r;
    assign bus.ack        = ack_r;
    assign bus.in_service = in_service_r;
    assign bus.spurious   = spurious_r;
    assign bus.vector     = vector_r;
endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed handshake scenarios plus randomized acceptances.
module tb_irq_controller;
    localparam int N_SRC  = 4;
    localparam int ADDR_W = 4;

    typedef struct {
        logic [ADDR_W-1:0] vec;
        logic              ack;
        logic              spur;
    } exp_t;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   ack_count = 0;
    int   vv_count  = 0;
    int   pushed    = 0;
    exp_t sb[$];

    irq_controller_if #(.N_SRC(N_SRC), .ADDR_W(ADDR_W)) bus ();

    irq_controller #(.N_SRC(N_SRC), .ADDR_W(ADDR_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: lowest-numbered owner wins, vector = 8 + index, no owner -> F.
    function automatic logic [ADDR_W-1:0] ref_vec(input logic [N_SRC-1:0] ie);
        for (int i = 0; i < N_SRC; i++) begin
            if (ie[i]) return ADDR_W'(8 + i);
        end
        return 4'hF;
    endfunction

    // Monitor: every vec_valid cycle must match the oldest expected acceptance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.ack) ack_count++;
            if (bus.ack && !bus.vec_valid) begin
                checks++;
                failures++;
                $display("FAIL ack_without_vec_valid actual=1 expected=0");
            end
            if (bus.vec_valid) begin
                vv_count++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_vec_valid actual=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    check("sb_vector", 32'(bus.vector), 32'(e.vec));
                    check("sb_ack", 32'(bus.ack), 32'(e.ack));
                    check("sb_spurious", 32'(bus.spurious), 32'(e.spur));
                    check("sb_in_service", 32'(bus.in_service), 32'd1);
                end
            end
        end
    end

    task automatic pulse_ei();
        bus.ei = 1'b1;
        tick();
        bus.ei = 1'b0;
    endtask

    task automatic pulse_di();
        bus.di = 1'b1;
        tick();
        bus.di = 1'b0;
    endtask

    task automatic pulse_reti();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic level, input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            if (bus.int_req === level) begin
                ok = 1;
                break;
            end
            tick();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic do_ack(input logic [ADDR_W-1:0] v, input logic a, input logic s, input logic with_di);
        exp_t e;
        e.vec = v;
        e.ack = a;
        e.spur = s;
        sb.push_back(e);
        pushed++;
        bus.int_ack = 1'b1;
        bus.di = with_di;
        tick();
        bus.int_ack = 1'b0;
        bus.di = 1'b0;
    endtask

    initial begin
        int acks_before;
        int stuck;
        logic ien_m;
        logic spur_m;
        logic [N_SRC-1:0] r_ie;
        logic use_di;
        logic [ADDR_W-1:0] ev;

        reset = 1'b0;
        bus.irq = 1'b0;
        bus.ie = '0;
        bus.ei = 1'b0;
        bus.di = 1'b0;
        bus.int_ack = 1'b0;
        bus.reti = 1'b0;
        repeat (3) tick();
        check("rst_int_req", 32'(bus.int_req), 32'd0);
        check("rst_vec_valid", 32'(bus.vec_valid), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_in_service", 32'(bus.in_service), 32'd0);
        check("rst_spurious", 32'(bus.spurious), 32'd0);
        check("rst_vector", 32'(bus.vector), 32'd0);
        reset = 1'b1;
        tick();

        // Basic acceptance with sync latency.
        pulse_ei();
        bus.ie = 4'b0100;
        bus.irq = 1'b1;
        tick();
        check("sync_lat_1", 32'(bus.int_req), 32'd0);
        tick();
        check("sync_lat_2", 32'(bus.int_req), 32'd0);
        tick();
        check("sync_lat_3", 32'(bus.int_req), 32'd1);
        acks_before = ack_count;
        do_ack(4'hA, 1'b1, 1'b0, 1'b0);
        check("ack_in_service", 32'(bus.in_service), 32'd1);
        check("ack_int_req_low", 32'(bus.int_req), 32'd0);
        tick();
        check("service_vec_valid_low", 32'(bus.vec_valid), 32'd0);
        check("one_ack_a", 32'(ack_count - acks_before), 32'd1);

        // Stray activity during SERVICE must not produce a new acceptance.
        bus.irq = 1'b0;
        tick();
        bus.irq = 1'b1;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        repeat (2) tick();
        check("service_no_req", 32'(bus.int_req), 32'd0);
        check("service_held", 32'(bus.in_service), 32'd1);
        pulse_reti();
        check("hold_in_service", 32'(bus.in_service), 32'd0);
        tick();
        check("idle_int_req", 32'(bus.int_req), 32'd0);
        tick();
        check("rerequest", 32'(bus.int_req), 32'd1);

        // Priority: source 1 beats source 2.
        bus.ie = 4'b0110;
        acks_before = ack_count;
        do_ack(4'h9, 1'b1, 1'b0, 1'b0);
        bus.irq = 1'b0;
        repeat (3) tick();
        pulse_reti();
        repeat (3) tick();
        check("one_ack_b", 32'(ack_count - acks_before), 32'd1);
        check("idle_after_b", 32'(bus.int_req), 32'd0);

        // Interrupts disabled: irq held, no request until ei.
        pulse_di();
        bus.irq = 1'b1;
        stuck = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.int_req) stuck++;
        end
        check("disabled_no_req", 32'(stuck), 32'd0);
        pulse_ei();
        check("ei_lat_0", 32'(bus.int_req), 32'd0);
        tick();
        check("ei_lat_1", 32'(bus.int_req), 32'd1);
        bus.irq = 1'b0;
        wait_req("withdraw_a", 1'b0, 8);
        repeat (3) tick();

        // 3-cycle irq pulse withdrawn before acknowledge.
        acks_before = ack_count;
        bus.irq = 1'b1;
        repeat (3) tick();
        bus.irq = 1'b0;
        check("pulse_req_up", 32'(bus.int_req), 32'd1);
        tick();
        check("pulse_req_1", 32'(bus.int_req), 32'd1);
        tick();
        check("pulse_req_2", 32'(bus.int_req), 32'd1);
        tick();
        check("pulse_req_fall", 32'(bus.int_req), 32'd0);
        repeat (3) tick();
        check("pulse_no_ack", 32'(ack_count - acks_before), 32'd0);

        // Spurious acknowledge, then ei clears the sticky flag.
        bus.ie = '0;
        bus.irq = 1'b1;
        wait_req("spur_req", 1'b1, 8);
        acks_before = ack_count;
        do_ack(4'hF, 1'b0, 1'b1, 1'b0);
        bus.irq = 1'b0;
        repeat (3) tick();
        pulse_reti();
        repeat (3) tick();
        check("spur_no_ack", 32'(ack_count - acks_before), 32'd0);
        check("spur_sticky", 32'(bus.spurious), 32'd1);
        pulse_ei();
        check("spur_cleared", 32'(bus.spurious), 32'd0);

        // Randomized acceptances against the reference model.
        ien_m = 1'b1;
        spur_m = 1'b0;
        for (int it = 0; it < 24; it++) begin
            if (!ien_m) begin
                pulse_ei();
                ien_m = 1'b1;
                spur_m = 1'b0;
            end
            r_ie = ($urandom_range(0, 5) == 0) ? '0 : N_SRC'($urandom_range(1, 15));
            use_di = ($urandom_range(0, 3) == 0);
            bus.ie = r_ie;
            bus.irq = 1'b1;
            wait_req("rnd_req", 1'b1, 8);
            repeat ($urandom_range(0, 3)) tick();
            bus.ie = r_ie;
            ev = ref_vec(r_ie);
            if (r_ie == '0) spur_m = 1'b1;
            do_ack(ev, (r_ie != '0), spur_m, use_di);
            if (use_di) ien_m = 1'b0;
            bus.irq = 1'b0;
            repeat ($urandom_range(2, 5)) tick();
            pulse_reti();
            repeat (3) tick();
            check("rnd_idle", 32'(bus.int_req), 32'd0);
        end

        // Async reset in the middle of SERVICE.
        pulse_ei();
        bus.ie = 4'b0001;
        bus.irq = 1'b1;
        wait_req("rst_req", 1'b1, 8);
        do_ack(4'h8, 1'b1, 1'b0, 1'b0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_in_service", 32'(bus.in_service), 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        stuck = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.int_req) stuck++;
        end
        check("post_rst_no_req", 32'(stuck), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("vec_valid_count", 32'(vv_count), 32'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Sits between the daisy-chained button interrupt sources and the CPU.
- Consumes the shared `irq` line and the per-button `ie` (interrupt-owner) flags, and presents a single request/acknowledge handshake to the CPU.
- On CPU acknowledge it resolves the winning source to a jump vector and returns the `ack` pulse that the buttons consume.
- Holds off further interrupts until the CPU signals return-from-interrupt.

Parameters:
- N_SRC, 4, number of interrupt sources; bit 0 is highest priority.
- ADDR_W, 4, width of the vector output (matches CPU address width).
- VEC_BASE, 4'h8, vector of source 0.
- VEC_STRIDE, 1, vector spacing between consecutive sources.
- SPUR_VEC, 4'hF, vector issued when no source owns the request at acknowledge.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq  in  1  wired interrupt request from the button chain, active high.
- ie  in  N_SRC  per-source ownership flags from the buttons; at most one is expected high.
- ei  in  1  one-cycle pulse from CPU: set global interrupt enable.
- di  in  1  one-cycle pulse from CPU: clear global interrupt enable.
- int_req  out  1  interrupt request to CPU.
- int_ack  in  1  one-cycle pulse from CPU at instruction boundary: request accepted.
- reti  in  1  one-cycle pulse from CPU: return from interrupt.
- vector  out  ADDR_W  jump address, valid while vec_valid is high.
- vec_valid  out  1  high for exactly one cycle after acceptance.
- ack  out  1  one-cycle pulse to all buttons.
- in_service  out  1  high while a handler is running.
- spurious  out  1  sticky flag, set on acknowledge with no owner; cleared by ei.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; ien = 0.
  - int_req, vec_valid, ack, in_service, spurious = 0; vector = 0.
  - Synchronizer flops = 0.
- irq passes through a 2-flop synchronizer, irq_s.
  - irq rising before edge N makes irq_s high after edge N+1.
  - int_req can therefore rise no earlier than after edge N+2.
- ien:
  - ei sets it and di clears it on the next edge.
  - If ei and di arrive in the same cycle, di wins and ien = 0.
- State IDLE:
  - int_req = 0.
  - If irq_s && ien, go to REQ.
- State REQ:
  - int_req = 1.
  - If irq_s drops before int_ack (the source withdrew), return to IDLE with int_req = 0 on the next edge.
  - If di arrives while in REQ, return to IDLE.
  - On int_ack, latch the winning source:
    - idx = lowest set bit of ie.
    - vector = VEC_BASE + idx*VEC_STRIDE, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - If ie == 0 at int_ack: vector = SPUR_VEC, spurious = 1, no ack pulse.
  - Then go to ACK.
- State ACK (exactly 1 cycle):
  - vec_valid = 1; ack = 1 (unless spurious); int_req = 0; in_service = 1.
  - Next state is SERVICE.
- State SERVICE:
  - in_service = 1; irq_s is ignored; ei/di still update ien.
  - On reti go to HOLD.
  - reti in any other state is ignored.
  - int_ack outside REQ is ignored.
- State HOLD (1 cycle):
  - in_service = 0.
  - Gives the buttons time to drop irq after ack; then go to IDLE.
  - A still-asserted irq_s re-requests normally from IDLE.
- vector holds its last value until the next acceptance.
- Nested interrupts are not supported.
- Simultaneous int_ack and irq_s falling in REQ: the acknowledge wins; the vector is resolved from ie sampled that cycle.
- Simultaneous int_ack and di in REQ: the acknowledge wins; ien still clears.
- Reset asserted mid-SERVICE: everything returns to reset values immediately; pending irq is re-requested only after ien is set again.

Test Plan:
- Reset low, then high; ei pulse; irq high at edge 10, ie = 4'b0100 → int_req high after edge 12. int_ack at edge 14 → vector = 4'hA, vec_valid and ack high for the cycle after edge 14, in_service = 1.
- ie = 4'b0110 at int_ack → vector = 4'h9 (source 1 wins over source 2); exactly one ack pulse.
- ien = 0, irq held high for 20 cycles → int_req stays 0. ei pulse → int_req rises 1 cycle later.
- irq pulse of 3 cycles, no int_ack → int_req rises, then falls 2–3 cycles after irq drops; ack never asserts.
- int_ack with ie = 0 → vector = 4'hF, spurious = 1, ack = 0. A subsequent ei clears spurious.
- In SERVICE, toggle irq and send extra int_ack pulses → no vec_valid or ack. reti → HOLD, then IDLE; with irq still high, int_req re-asserts the cycle after IDLE. Async reset in SERVICE → in_service = 0 immediately.
